sr_latch_driver: RTL
====================

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter PULSE_CYCLES, default 2: cycles the selected active-low latch input is held low; legal range 1..15.
REQ-002 Parameter SETTLE_CYCLES, default 1: recovery cycles with both latch inputs high after each operation; legal range 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 4: maximum CHECK cycles spent waiting for latch confirmation; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  driver can accept a request.
REQ-008 req_val  input  1  target latch value; 1 = set, 0 = reset.
REQ-009 latch_q  input  1  latch output feedback, asynchronous to clk.
REQ-010 latch_s_n  output  1  active-low set drive to the NAND SR latch.
REQ-011 latch_r_n  output  1  active-low reset drive to the NAND SR latch.
REQ-012 done  output  1  one-cycle pulse when the latch is confirmed at the target value.
REQ-013 err  output  1  one-cycle pulse when confirmation times out.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The design SHALL be an FSM with states IDLE, PULSE, CHECK and RECOVER; all outputs SHALL be registered or decoded from registered state only.
REQ-016 req_ready SHALL be high exactly when state is IDLE; a request is accepted on an edge where req_valid and req_ready are both high, and req_val is captured on that edge.
REQ-017 On acceptance the FSM SHALL enter PULSE: latch_s_n low if captured value is 1, latch_r_n low if 0, held for exactly PULSE_CYCLES cycles.
REQ-018 latch_s_n and latch_r_n SHALL never be low in the same cycle, under any input sequence, including reset.
REQ-019 After PULSE the FSM SHALL enter CHECK with both lines high and SHALL compare synchronized latch_q against the captured target on each edge.
REQ-020 On the first matching edge within TIMEOUT_CYCLES CHECK cycles, done SHALL pulse for one cycle and the FSM SHALL enter RECOVER.
REQ-021 If no match occurs within TIMEOUT_CYCLES cycles, err SHALL pulse for one cycle and the FSM SHALL enter RECOVER; the latch is not retried.
REQ-022 done and err SHALL never be high in the same cycle; exactly one of them SHALL pulse per accepted request.
REQ-023 RECOVER SHALL hold both lines high for SETTLE_CYCLES cycles and then return to IDLE.
REQ-024 A request whose target equals the current latch value SHALL still be pulsed and confirmed normally.
REQ-025 req_valid high while not ready SHALL be ignored; the request is not queued.
REQ-026 The shared cycle counter SHALL be 4 bits wide, reload on each state entry, and never wrap.
REQ-027 latch_q SHALL pass through a 2-flop synchronizer before use, adding 2 cycles of confirmation latency.

Reset
REQ-028 While rst is high at an edge: state is IDLE, latch_s_n and latch_r_n are 1, done, err and busy are 0, the counter is 0, and synchronizer flops are 0.
REQ-029 Reset asserted mid-operation SHALL abort the operation at the next edge with no done or err pulse; req_ready SHALL be high in the first cycle after rst falls.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default values of PULSE_CYCLES, SETTLE_CYCLES and TIMEOUT_CYCLES.
REQ-031 The synchronizer SHALL be a separate sub-module named sync2 (1-bit, two flops, synchronous active-high reset); the bench SHALL drive it with a real NAND SR latch model.

Verification
REQ-032 Set: latch initially 0, req_val=1 accepted at cycle 0 -> latch_s_n low in cycles 1-2, latch_q=1, done pulses by cycle 6, req_ready high after 1 RECOVER cycle.
REQ-033 Reset path: latch initially 1, req_val=0 -> latch_r_n low for 2 cycles, latch_s_n stays 1, then done and latch_q=0.
REQ-034 Timeout: latch_q forced to 0, req_val=1 -> err pulses exactly 4 CHECK cycles after PULSE ends, done never asserts, then IDLE.
REQ-035 Mid-operation reset: rst asserted in cycle 2 of PULSE -> both lines high next edge, no done or err, req_ready high the cycle after rst falls.
REQ-036 Back-to-back: req_valid held high with alternating req_val 1,0,1 -> three requests accepted only in IDLE, three done pulses, latch sequence 1,0,1.
REQ-037 All scenarios SHALL include continuous assertions that latch_s_n and latch_r_n are never both low and that done and err are never both high.

Source files
------------

// File: rtl/sr_latch_driver_pkg.sv
// sr_latch_driver_pkg
//   Shared definitions for the NAND SR latch driver: FSM state encoding,
//   default timing parameters and the width of the shared cycle counter.
package sr_latch_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_CHECK,
    ST_RECOVER
  } state_t;

  localparam int unsigned PULSE_CYCLES_DEF   = 2;
  localparam int unsigned SETTLE_CYCLES_DEF  = 1;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 4;

  localparam int unsigned CNT_W = 4;

  // A phase lasting N cycles counts down from N-1 to 0.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
    return CNT_W'(cycles - 32'd1);
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2
//   Two-flop synchronizer for a single asynchronous bit.
//   i_clk : sampling clock
//   i_rst : synchronous active-high reset, clears both flops
//   i_d   : asynchronous input
//   o_q   : synchronized output, two cycles of latency
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Drives an external NAND SR latch: pulses the selected active-low input,
//   then waits for the synchronized latch output to confirm the target value,
//   then holds both inputs high for a recovery period.
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : request present
//   req_ready  : high exactly while IDLE
//   req_val    : target latch value (1 = set, 0 = reset)
//   latch_q    : latch output feedback, asynchronous
//   latch_s_n  : active-low set drive
//   latch_r_n  : active-low reset drive
//   done       : one-cycle pulse on confirmation
//   err        : one-cycle pulse on confirmation timeout
//   busy       : high whenever not IDLE
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = PULSE_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_val,
  input  logic latch_q,
  output logic latch_s_n,
  output logic latch_r_n,
  output logic done,
  output logic err,
  output logic busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_target;
  logic             r_s_n;
  logic             r_r_n;
  logic             r_done;
  logic             r_err;
  logic             w_q_sync;

  sync2 u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (latch_q),
    .o_q   (w_q_sync)
  );

  // The counter is reloaded on every state entry and only decremented while
  // non-zero, so it can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_target <= 1'b0;
      r_s_n    <= 1'b1;
      r_r_n    <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_s_n <= 1'b1;
          r_r_n <= 1'b1;
          if (req_valid) begin
            r_state  <= ST_PULSE;
            r_cnt    <= cnt_load(PULSE_CYCLES);
            r_target <= req_val;
            // Complementary drive: exactly one line goes low.
            r_s_n    <= ~req_val;
            r_r_n    <= req_val;
          end
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= ST_CHECK;
            r_cnt   <= cnt_load(TIMEOUT_CYCLES);
            r_s_n   <= 1'b1;
            r_r_n   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          r_s_n <= 1'b1;
          r_r_n <= 1'b1;
          if (w_q_sync == r_target) begin
            r_done  <= 1'b1;
            r_state <= ST_RECOVER;
            r_cnt   <= cnt_load(SETTLE_CYCLES);
          end else if (r_cnt == '0) begin
            r_err   <= 1'b1;
            r_state <= ST_RECOVER;
            r_cnt   <= cnt_load(SETTLE_CYCLES);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RECOVER: begin
          r_s_n <= 1'b1;
          r_r_n <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_s_n   <= 1'b1;
          r_r_n   <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign latch_s_n = r_s_n;
  assign latch_r_n = r_r_n;
  assign done      = r_done;
  assign err       = r_err;

endmodule
